// File: rtl/nyan_spi_pkg.sv
// Shared types and address constants for the SPI command decoder / register map.
package nyan_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD_TURN,
    ST_RD_DATA,
    ST_WR_DATA
  } state_t;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned CMD_RD_BIT = 7;

  localparam logic [ADDR_W-1:0] ADDR_ID       = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_KEY_BASE = 7'h10;
  localparam logic [ADDR_W-1:0] ADDR_CFG_BASE = 7'h40;

  function automatic logic [7:0] status_byte(input logic err, input logic any_key);
    return {6'b0, err, any_key};
  endfunction

endpackage

// File: rtl/nyan_sync2.sv
// Two-flop synchroniser for a single asynchronous pin; reset value is selectable.
module nyan_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nyan_spi_regmap.sv
// SPI byte-stream command decoder and register map (ID, STATUS, key bitmap, config bank).
// Define NYAN_SPI_SNAPSHOT_EN to freeze the key bitmap at each frame start.
module nyan_spi_regmap
  import nyan_spi_pkg::*;
#(
  parameter int unsigned NUM_KEYS  = 64,
  parameter int unsigned NUM_CFG   = 8,
  parameter logic [7:0]  DEVICE_ID = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss,
  input  logic                  rx_done,
  input  logic [7:0]            rx_data,
  output logic [7:0]            tx_data,
  input  logic [NUM_KEYS-1:0]   keys,
  output logic [8*NUM_CFG-1:0]  cfg,
  output logic                  cfg_we,
  output logic                  busy
);

  localparam int unsigned NUM_KEY_BYTES = NUM_KEYS / 8;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                err;
  logic                ss_s;
  logic                ss_q;
  logic                ss_fall_c;
  logic [NUM_KEYS-1:0] keys_src;
  logic [7:0]          status_c;
  logic [7:0]          rd_val_c;
  logic                rd_hit_c;
  logic                wr_cfg_hit_c;
  logic [3:0]          wr_cfg_idx_c;

  // Sync resets to "selected" so a pin already low at reset release is not taken as a frame start.
  nyan_sync2 #(.RST_VAL(1'b0)) u_ss_sync (
    .clk (clk),
    .rst (rst),
    .d   (ss),
    .q   (ss_s)
  );

  assign ss_fall_c = ss_q & ~ss_s;

`ifdef NYAN_SPI_SNAPSHOT_EN
  logic [NUM_KEYS-1:0] key_snap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_snap <= '0;
    end else if (ss_fall_c) begin
      key_snap <= keys;
    end
  end

  assign keys_src = key_snap;
`else
  assign keys_src = keys;
`endif

  assign status_c = status_byte(err, |keys_src);

  // Read decode of the register addressed by rd_ptr.
  always_comb begin
    rd_val_c = 8'h00;
    rd_hit_c = 1'b0;
    if (rd_ptr == ADDR_ID) begin
      rd_val_c = DEVICE_ID;
      rd_hit_c = 1'b1;
    end
    if (rd_ptr == ADDR_STATUS) begin
      rd_val_c = status_c;
      rd_hit_c = 1'b1;
    end
    for (int unsigned j = 0; j < NUM_KEY_BYTES; j++) begin
      if (rd_ptr == ADDR_KEY_BASE + 7'(j)) begin
        rd_val_c = keys_src[8*j +: 8];
        rd_hit_c = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_CFG; i++) begin
      if (rd_ptr == ADDR_CFG_BASE + 7'(i)) begin
        rd_val_c = cfg[8*i +: 8];
        rd_hit_c = 1'b1;
      end
    end
  end

  always_comb begin
    wr_cfg_hit_c = 1'b0;
    wr_cfg_idx_c = 4'd0;
    for (int unsigned i = 0; i < NUM_CFG; i++) begin
      if (addr == ADDR_CFG_BASE + 7'(i)) begin
        wr_cfg_hit_c = 1'b1;
        wr_cfg_idx_c = 4'(i);
      end
    end
  end

  // Byte processing runs first; a high ss_s then overrides the state so the last byte still lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr    <= '0;
      rd_ptr  <= '0;
      err     <= 1'b0;
      cfg     <= '0;
      cfg_we  <= 1'b0;
      tx_data <= 8'h00;
      busy    <= 1'b0;
      ss_q    <= 1'b0;
    end else begin
      ss_q    <= ss_s;
      cfg_we  <= 1'b0;
      tx_data <= (state == ST_RD_TURN || state == ST_RD_DATA) ? rd_val_c : status_c;

      if (rx_done) begin
        case (state)
          ST_CMD: begin
            addr   <= rx_data[ADDR_W-1:0];
            rd_ptr <= rx_data[ADDR_W-1:0];
            state  <= rx_data[CMD_RD_BIT] ? ST_RD_TURN : ST_WR_DATA;
          end
          ST_RD_TURN, ST_RD_DATA: begin
            if (!rd_hit_c) err <= 1'b1;
            rd_ptr <= rd_ptr + 7'd1;
            state  <= ST_RD_DATA;
          end
          ST_WR_DATA: begin
            if (wr_cfg_hit_c) begin
              for (int unsigned i = 0; i < NUM_CFG; i++) begin
                if (wr_cfg_idx_c == 4'(i)) cfg[8*i +: 8] <= rx_data;
              end
              cfg_we <= 1'b1;
            end else if (addr == ADDR_STATUS) begin
              err <= 1'b0;
            end else begin
              err <= 1'b1;
            end
            addr <= addr + 7'd1;
          end
          default: ;
        endcase
      end

      if (ss_s) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (ss_fall_c) begin
        state <= ST_CMD;
        busy  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nyan_spi_regmap.sv
// Self-checking bench: byte-level SPI frames against an address-map reference model.
module tb_nyan_spi_regmap;

  localparam int NK = 64;
  localparam int NC = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            ss;
  logic            rx_done;
  logic [7:0]      rx_data;
  logic [7:0]      tx_data;
  logic [NK-1:0]   keys;
  logic [8*NC-1:0] cfg;
  logic            cfg_we;
  logic            busy;

  always #5 clk = ~clk;

  nyan_spi_regmap #(.NUM_KEYS(NK), .NUM_CFG(NC), .DEVICE_ID(8'hA5)) dut (
    .clk     (clk),
    .rst     (rst),
    .ss      (ss),
    .rx_done (rx_done),
    .rx_data (rx_data),
    .tx_data (tx_data),
    .keys    (keys),
    .cfg     (cfg),
    .cfg_we  (cfg_we),
    .busy    (busy)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  cfg_m [NC];
  logic        err_m;
  logic [63:0] keys_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] status_m();
    return {6'b0, err_m, keys_m != 64'd0};
  endfunction

  function automatic bit mapped(input int a);
    return (a == 0) || (a == 1) || (a >= 16 && a < 16 + NK/8) || (a >= 64 && a < 64 + NC);
  endfunction

  function automatic logic [7:0] reg_m(input int a);
    if (a == 0) return 8'hA5;
    if (a == 1) return status_m();
    if (a >= 16 && a < 16 + NK/8) return 8'(keys_m >> (8 * (a - 16)));
    if (a >= 64 && a < 64 + NC) return cfg_m[a - 64];
    return 8'h00;
  endfunction

  function automatic logic [8*NC-1:0] cfg_flat();
    logic [8*NC-1:0] r;
    for (int i = 0; i < NC; i++) r[8*i +: 8] = cfg_m[i];
    return r;
  endfunction

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One received byte; returns what the slave would load as din at the rx_done edge.
  task automatic xfer(input logic [7:0] b, output logic [7:0] loaded);
    ticks(8);
    rx_done = 1'b1;
    rx_data = b;
    loaded  = tx_data;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic frame_begin();
    keys_m = keys;
    ss = 1'b0;
    ticks(5);
  endtask

  task automatic frame_end();
    ss = 1'b1;
    ticks(6);
    chk("busy_idle", {63'd0, busy}, 64'd0);
    chk("status_idle", {56'd0, tx_data}, {56'd0, status_m()});
  endtask

  task automatic rd_frame(input logic [6:0] a, input int n, input logic [63:0] keys_mid, input bit change);
    logic [7:0] got;
    int p;
    frame_begin();
    chk("busy_frame", {63'd0, busy}, 64'd1);
    xfer({1'b1, a}, got);
    chk("rd_cmd", {56'd0, got}, {56'd0, status_m()});
    p = int'(a);
    for (int k = 0; k <= n; k++) begin
      xfer(8'($urandom), got);
      chk("rd_byte", {56'd0, got}, {56'd0, reg_m(p)});
      if (!mapped(p)) err_m = 1'b1;
      p = (p + 1) % 128;
      if (change && k == 0) keys = keys_mid;
    end
    frame_end();
  endtask

  task automatic wr_frame(input logic [6:0] a, input logic [7:0] data[$]);
    logic [7:0] got;
    int p;
    bit we_exp;
    frame_begin();
    xfer({1'b0, a}, got);
    chk("wr_cmd", {56'd0, got}, {56'd0, status_m()});
    p = int'(a);
    foreach (data[k]) begin
      xfer(data[k], got);
      chk("wr_byte", {56'd0, got}, {56'd0, status_m()});
      we_exp = (p >= 64 && p < 64 + NC);
      if (we_exp) cfg_m[p - 64] = data[k];
      else if (p == 1) err_m = 1'b0;
      else err_m = 1'b1;
      chk("cfg_we", {63'd0, cfg_we}, {63'd0, we_exp});
      chk("cfg_now", cfg, cfg_flat());
      p = (p + 1) % 128;
    end
    frame_end();
  endtask

  function automatic logic [6:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return 7'($urandom_range(0, 1));
      1:       return 7'(16 + $urandom_range(0, NK/8));
      2:       return 7'(64 + $urandom_range(0, NC));
      3:       return 7'($urandom_range(126, 127));
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    logic [7:0] q[$];
    logic [7:0] junk;
    rst = 1'b1; ss = 1'b1; rx_done = 1'b0; rx_data = 8'h00;
    keys = 64'h0000_0000_0000_8001;
    err_m = 1'b0; keys_m = keys;
    for (int i = 0; i < NC; i++) cfg_m[i] = 8'h00;

    ticks(2);
    chk("rst_tx", {56'd0, tx_data}, 64'd0);
    chk("rst_cfg", cfg, 64'd0);
    chk("rst_we", {63'd0, cfg_we}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    ticks(3);
    chk("status_post_rst", {56'd0, tx_data}, {56'd0, status_m()});

    // Read ID, burst config write, key bytes.
    rd_frame(7'h00, 1, 64'd0, 1'b0);
    q = {8'h11, 8'h22};
    wr_frame(7'h40, q);
    chk("cfg_lo", {48'd0, cfg[15:0]}, 64'h2211);
    rd_frame(7'h10, 2, 64'd0, 1'b0);
`ifdef NYAN_SPI_SNAPSHOT_EN
    rd_frame(7'h10, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    keys = 64'h0000_0000_0000_8001;
`endif

    // Unmapped read then wrap to ID; clearing err via STATUS write.
    rd_frame(7'h7F, 2, 64'd0, 1'b0);
    chk("err_set", {63'd0, err_m}, 64'd1);
    q = {8'h00};
    wr_frame(7'h01, q);

    // Abort mid data byte: no rx_done, so nothing is written.
    frame_begin();
    xfer(8'h40, junk);
    ticks(4);
    ss = 1'b1;
    ticks(6);
    chk("abort_cfg", cfg, cfg_flat());
    chk("abort_busy", {63'd0, busy}, 64'd0);
    rd_frame(7'h40, 2, 64'd0, 1'b0);

    // Asynchronous reset in the middle of a read.
    frame_begin();
    xfer(8'h80, junk);
    xfer(8'h00, junk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx", {56'd0, tx_data}, 64'd0);
    chk("mid_rst_cfg", cfg, 64'd0);
    chk("mid_rst_we", {63'd0, cfg_we}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < NC; i++) cfg_m[i] = 8'h00;
    err_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ticks(6);
    chk("dropped_frame", {63'd0, busy}, 64'd0);
    ss = 1'b1;
    ticks(6);
    rd_frame(7'h00, 1, 64'd0, 1'b0);

    // Randomised frames.
    for (int f = 0; f < 40; f++) begin
      keys = ($urandom_range(0, 3) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
      ticks(2);
      if ($urandom_range(0, 1) == 1) begin
        rd_frame(pick_addr(), $urandom_range(1, 4), 64'd0, 1'b0);
      end else begin
        q = {};
        for (int k = 0, n = $urandom_range(1, 4); k < n; k++) q.push_back(8'($urandom));
        wr_frame(pick_addr(), q);
      end
    end
    chk("cfg_final", cfg, cfg_flat());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
